baud_generator: RTL and testbench

BAUD_GENERATOR -- requirements
Module: baud_generator

---
 rtl/baud_pkg.sv | 19 +
 rtl/baud_nco.sv | 34 +++
 rtl/baud_generator.sv | 56 +++++
 tb/tb_baud_generator.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/baud_pkg.sv
// Shared baud-rate constants and the NCO increment calculation.
// Latency: n/a (elaboration-time only).
// Backpressure: n/a.
package baud_pkg;

    localparam int unsigned CLK_FREQ_DEF  = 25_000_000;
    localparam int unsigned BAUD_RATE_DEF = 115_200;

    // Rounded phase increment: round(rate * 2^acc_width / clk_freq).
    // TX and RX both call this so they always agree on the bit rate.
    function automatic logic [63:0] calc_inc(
        input logic [63:0] clk_freq,
        input logic [63:0] rate,
        input int unsigned acc_width
    );
        calc_inc = ((rate << acc_width) + (clk_freq >> 1)) / clk_freq;
    endfunction

endpackage

// File: rtl/baud_nco.sv
// One phase accumulator; the registered carry out is the tick.
// Latency: tick is high the cycle after the edge whose sum carries.
// Backpressure: none; enable low clears phase and suppresses ticks.
module baud_nco #(
    parameter int unsigned            ACC_WIDTH = 16,
    parameter logic [ACC_WIDTH-1:0]   INC       = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH:0]   sum;

    // Widen by one bit so the carry is visible; it marks a wrap of the phase.
    assign sum = {1'b0, acc} + {1'b0, INC};

    // Accumulate while enabled; reset and disable both drop all residual phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc  <= '0;
            tick <= 1'b0;
        end else if (!enable) begin
            acc  <= '0;
            tick <= 1'b0;
        end else begin
            acc  <= sum[ACC_WIDTH-1:0];
            tick <= sum[ACC_WIDTH];
        end
    end

endmodule

// File: rtl/baud_generator.sv
// Fractional-rate bit and oversample tick generator built from two NCOs.
// Latency: first BaudTick follows the carrying edge by one register stage.
// Backpressure: none; ticks are free-running pulses gated by enable.
module baud_generator
    import baud_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = CLK_FREQ_DEF,
    parameter int unsigned BAUD_RATE  = BAUD_RATE_DEF,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned ACC_WIDTH  = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic BaudTick,
    output logic OversampleTick
);

    localparam logic [63:0] OS_RATE    = 64'(BAUD_RATE) * 64'(OVERSAMPLE);
    localparam logic [63:0] INC_BAUD_W = calc_inc(64'(CLK_FREQ), 64'(BAUD_RATE), ACC_WIDTH);
    localparam logic [63:0] INC_OS_W   = calc_inc(64'(CLK_FREQ), OS_RATE, ACC_WIDTH);

    // Keeping the oversample rate below half the clock keeps INC_OS under
    // half the accumulator range, so no tick can repeat on consecutive cycles.
    localparam logic [ACC_WIDTH-1:0] INC_BAUD = INC_BAUD_W[ACC_WIDTH-1:0];
    localparam logic [ACC_WIDTH-1:0] INC_OS   = INC_OS_W[ACC_WIDTH-1:0];

    if (INC_BAUD_W == 64'd0) begin : g_bad_inc
        $fatal(1, "baud_generator: BAUD_RATE too low for ACC_WIDTH (increment is 0)");
    end

    if ((OS_RATE * 64'd2) > 64'(CLK_FREQ)) begin : g_bad_os
        $fatal(1, "baud_generator: BAUD_RATE*OVERSAMPLE exceeds CLK_FREQ/2");
    end

    baud_nco #(
        .ACC_WIDTH (ACC_WIDTH),
        .INC       (INC_BAUD)
    ) u_nco_baud (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .tick   (BaudTick)
    );

    baud_nco #(
        .ACC_WIDTH (ACC_WIDTH),
        .INC       (INC_OS)
    ) u_nco_os (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .tick   (OversampleTick)
    );

endmodule

// File: tb/tb_baud_generator.sv
// Bench for baud_generator: default build plus a 50 MHz / 9600 baud build.
// Reference: tick after the n-th enabled edge iff floor(n*INC/2^16) steps up.
// Inputs are driven 1 ns after a rising edge; outputs are sampled there too.
module tb_baud_generator;

    logic clk = 1'b0;
    logic rst;
    logic enable;
    logic baud_tick, os_tick, baud_tick2, os_tick2;

    always #5 clk = ~clk;

    baud_generator dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .BaudTick       (baud_tick),
        .OversampleTick (os_tick)
    );

    baud_generator #(
        .CLK_FREQ  (50_000_000),
        .BAUD_RATE (9600)
    ) dut2 (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .BaudTick       (baud_tick2),
        .OversampleTick (os_tick2)
    );

    localparam longint unsigned PERIOD = 65536;

    int n_tests = 0;
    int n_fail  = 0;

    // Hand-derived increments: default baud, default x16, 9600 baud, 9600 x16.
    longint unsigned inc_tab [4];
    string           tick_name [4];

    longint unsigned n_edges;          // enabled edges since the last restart
    int              cnt [4];          // ticks seen in the current window
    longint unsigned prev_edge [4];    // edge index of the previous tick
    bit              track_spacing;
    bit              check_acc;

    typedef struct {
        logic rst;
        logic enable;
        int   cycles;
        int   exp_b;
        int   exp_o;
        int   exp_b2;
        int   exp_o2;
    } vec_t;

    vec_t tbl [5];

    function automatic logic model_tick(longint unsigned n, longint unsigned inc);
        if (n == 0) return 1'b0;
        return ((n * inc) / PERIOD) != (((n - 1) * inc) / PERIOD);
    endfunction

    task automatic check(string name, longint act, longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: update the reference from the inputs seen at the edge, then compare.
    task automatic step();
        logic            r, e;
        logic [3:0]      act;
        longint unsigned fl, ce;
        r = rst;
        e = enable;
        @(posedge clk);
        if (r || !e) n_edges = 0;
        else         n_edges++;
        #1;
        act = {os_tick2, baud_tick2, os_tick, baud_tick};
        for (int i = 0; i < 4; i++) begin
            check(tick_name[i], longint'(act[i]), longint'(model_tick(n_edges, inc_tab[i])));
            if (act[i]) begin
                cnt[i]++;
                if (track_spacing && prev_edge[i] != 0) begin
                    fl = PERIOD / inc_tab[i];
                    ce = (PERIOD + inc_tab[i] - 1) / inc_tab[i];
                    if (n_edges - prev_edge[i] == ce)
                        check({tick_name[i], "_spacing"}, longint'(ce), longint'(ce));
                    else
                        check({tick_name[i], "_spacing"}, longint'(n_edges - prev_edge[i]), longint'(fl));
                end
                prev_edge[i] = n_edges;
            end
        end
        if (check_acc) begin
            check("acc_baud_in_reset", longint'(dut.u_nco_baud.acc), 0);
            check("acc_os_in_reset",   longint'(dut.u_nco_os.acc), 0);
        end
    endtask

    // Edges from now until the first default BaudTick; -1 if the bound expires.
    task automatic edges_to_tick(input int bound, output int edges);
        edges = -1;
        for (int k = 1; k <= bound; k++) begin
            step();
            if (baud_tick) begin
                edges = k;
                break;
            end
        end
    endtask

    initial begin
        int e;
        int found;

        inc_tab   = '{302, 4832, 13, 201};
        tick_name = '{"baud", "os", "baud2", "os2"};
        n_edges   = 0;
        track_spacing = 1'b0;
        check_acc     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cnt[i] = 0;
            prev_edge[i] = 0;
        end

        //            rst   en  cycles  b    o     b2  o2
        tbl[0] = '{1'b1, 1'b1,  1000,   0,   0,    0,  0};
        tbl[1] = '{1'b0, 1'b1,   217,   0,  15,    0,  0};
        tbl[2] = '{1'b0, 1'b1,     1,   1,   1,    0,  0};
        tbl[3] = '{1'b0, 1'b0,    50,   0,   0,    0,  0};
        tbl[4] = '{1'b0, 1'b1, 65536, 302, 4832,  13, 201};

        // Reset applies without any clock edge.
        rst = 1'b1;
        enable = 1'b0;
        #2;
        check("reset_baud", longint'(baud_tick), 0);
        check("reset_os",   longint'(os_tick), 0);
        check("reset_baud2", longint'(baud_tick2), 0);
        check("reset_os2",  longint'(os_tick2), 0);
        @(posedge clk);
        #1;

        for (int v = 0; v < 5; v++) begin
            rst    = tbl[v].rst;
            enable = tbl[v].enable;
            for (int i = 0; i < 4; i++) begin
                cnt[i] = 0;
                prev_edge[i] = 0;
            end
            track_spacing = (v == 4);
            check_acc     = tbl[v].rst;
            for (int c = 0; c < tbl[v].cycles; c++) step();
            check($sformatf("row%0d_baud_count", v),  cnt[0], tbl[v].exp_b);
            check($sformatf("row%0d_os_count", v),    cnt[1], tbl[v].exp_o);
            check($sformatf("row%0d_baud2_count", v), cnt[2], tbl[v].exp_b2);
            check($sformatf("row%0d_os2_count", v),   cnt[3], tbl[v].exp_o2);
        end
        track_spacing = 1'b0;
        check_acc     = 1'b0;

        // Disable mid-period: phase is dropped, next tick 218 edges after re-enable.
        enable = 1'b1;
        for (int c = 0; c < 100; c++) step();
        enable = 1'b0;
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        for (int c = 0; c < 50; c++) step();
        check("disabled_baud_count", cnt[0], 0);
        check("disabled_os_count",   cnt[1], 0);
        enable = 1'b1;
        edges_to_tick(400, e);
        check("reenable_first_tick_edge", e, 218);

        // Async reset while BaudTick is high, between edges.
        found = 0;
        for (int k = 0; k < 300 && found == 0; k++) begin
            step();
            if (baud_tick) found = 1;
        end
        check("tick_found_before_async_rst", found, 1);
        #3;
        rst = 1'b1;
        #1;
        n_edges = 0;
        check("async_rst_baud", longint'(baud_tick), 0);
        check("async_rst_os",   longint'(os_tick), 0);
        check("async_rst_acc",  longint'(dut.u_nco_baud.acc), 0);
        for (int c = 0; c < 3; c++) step();
        rst = 1'b0;
        edges_to_tick(400, e);
        check("post_rst_first_tick_edge", e, 218);

        // Random enable/reset activity against the reference.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(39, 0) == 0) enable = ~enable;
            rst = ($urandom_range(199, 0) == 0);
            step();
        end
        rst = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
